// File: rtl/dsp_logic_pipe_if.sv
// Operand/result handshake bundle for dsp_logic_pipe.
// The master side feeds operands and drives out_ready; the slave side is the logic unit.
interface dsp_logic_pipe_if #(
    parameter int width = 48
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] y;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/dsp_logic_pipe.sv
// Pipelined bitwise logic unit shaped after a DSP48E2 in logic mode (X=A:B, Y=0/ones, Z=C).
// One advance enable drives every stage, so the whole pipeline stalls as a unit.
module dsp_logic_pipe #(
    parameter int width   = 48,
    parameter int latency = 2
) (
    input logic               clock,
    input logic               reset,
    dsp_logic_pipe_if.slave   bus
);
    localparam int dw = 48;

    if (width < 1 || width > 48) begin : g_bad_width
        $error("dsp_logic_pipe: width must be 1..48");
    end
    if (latency < 1 || latency > 3) begin : g_bad_latency
        $error("dsp_logic_pipe: latency must be 1..3");
    end

    typedef struct packed {
        logic       x_en;     // OPMODE X mux: A:B or zero
        logic       y_ones;   // OPMODE[3:2]: Y term zero or all-ones
        logic [3:0] alumode;
    } ctrl_t;

    logic [latency-1:0] valid_reg;
    logic [dw-1:0]      p_reg;
    logic               advance;
    logic               out_valid;
    ctrl_t              ctrl_in;
    logic [dw-1:0]      ab_in;
    logic [dw-1:0]      c_in;

    assign out_valid     = valid_reg[latency-1];
    assign advance       = ~out_valid | bus.out_ready;
    assign bus.in_ready  = advance & reset;
    assign bus.out_valid = out_valid;
    assign bus.busy      = |valid_reg;
    assign bus.y         = p_reg[width-1:0];

    // a feeds the A:B concatenation (a[17:0] -> B, a[47:18] -> A); b feeds C
    assign ab_in = dw'(bus.a);
    assign c_in  = dw'(bus.b);

    always_comb begin
        ctrl_in = '{x_en: 1'b1, y_ones: 1'b0, alumode: 4'b0100};
        case (bus.op)
            3'b000: ctrl_in = '{x_en: 1'b1, y_ones: 1'b0, alumode: 4'b0100};
            3'b001: ctrl_in = '{x_en: 1'b1, y_ones: 1'b1, alumode: 4'b0100};
            3'b010: ctrl_in = '{x_en: 1'b1, y_ones: 1'b0, alumode: 4'b1100};
            3'b011: ctrl_in = '{x_en: 1'b1, y_ones: 1'b1, alumode: 4'b1100};
            3'b100: ctrl_in = '{x_en: 1'b1, y_ones: 1'b0, alumode: 4'b1110};
            3'b101: ctrl_in = '{x_en: 1'b1, y_ones: 1'b1, alumode: 4'b1110};
            3'b110: ctrl_in = '{x_en: 1'b1, y_ones: 1'b0, alumode: 4'b1101};
            default: ctrl_in = '{x_en: 1'b0, y_ones: 1'b0, alumode: 4'b1100};
        endcase
    end

    // Logic-unit behaviour: XOR family folds the Y term in; AND family turns into OR when Y is ones
    function automatic logic [dw-1:0] logic_unit(input logic [dw-1:0] x,
                                                 input logic [dw-1:0] z,
                                                 input ctrl_t ctl);
        logic [dw-1:0] xm;
        logic [dw-1:0] ym;
        logic [dw-1:0] zm;
        logic [dw-1:0] t;
        logic [dw-1:0] r;
        xm = ctl.x_en ? x : '0;
        ym = ctl.y_ones ? '1 : '0;
        zm = ctl.alumode[0] ? ~z : z;
        if (ctl.alumode[3:2] == 2'b01) begin
            t = xm ^ ym ^ z;
            r = ctl.alumode[0] ? ~t : t;
        end else begin
            t = ctl.y_ones ? (xm | zm) : (xm & zm);
            r = ctl.alumode[1] ? ~t : t;
        end
        return r;
    endfunction

    // Stage 0 is the raw input; stages 1..latency-1 are A/B/C and control registers
    for (genvar gi = 0; gi < latency; gi++) begin : g_stage
        logic [dw-1:0] ab;
        logic [dw-1:0] c;
        ctrl_t         ctrl;
        if (gi == 0) begin : g_in
            assign ab   = ab_in;
            assign c    = c_in;
            assign ctrl = ctrl_in;
        end else begin : g_reg
            always_ff @(posedge clock) begin
                if (!reset) begin
                    ab   <= '0;
                    c    <= '0;
                    ctrl <= '0;
                end else if (advance) begin
                    ab   <= g_stage[gi-1].ab;
                    c    <= g_stage[gi-1].c;
                    ctrl <= g_stage[gi-1].ctrl;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            p_reg <= '0;
        end else if (advance) begin
            p_reg <= logic_unit(g_stage[latency-1].ab, g_stage[latency-1].c,
                                g_stage[latency-1].ctrl);
        end
    end

    for (genvar gi = 0; gi < latency; gi++) begin : g_valid
        always_ff @(posedge clock) begin
            if (!reset) begin
                valid_reg[gi] <= 1'b0;
            end else if (advance) begin
                if (gi == 0) begin
                    valid_reg[gi] <= bus.in_valid & bus.in_ready;
                end else begin
                    valid_reg[gi] <= valid_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    end

    // Upper P bits only matter for narrow widths, where they are intentionally dropped
    logic unused_upper;
    assign unused_upper = ^p_reg;
endmodule

// File: doc/dsp_logic_pipe.md
Name: dsp_logic_pipe

Overview:
- Pipelined, handshaked bitwise logic unit built on a single DSP48E2 (ALU used in logic mode, multiplier unused).
- Successor to the fixed-function combinational DSP XOR. Adds run-time op select, parametrised width and latency, and valid/ready flow control with full-pipeline stall.
- Sits in the ultrascale primitive library as the DSP-mapped target for logic ops that need a registered, backpressurable path.

Parameters:
- width, 48, operand/result width in bits; legal 1..48, else elaboration $error.
- latency, 2, cycles from input acceptance to out_valid; legal 1..3, else elaboration $error.

Ports:
- clock  input  1  single clock for all state.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- op  input  3  operation, sampled with operands.
- a  input  width  first operand.
- b  input  width  second operand.
- out_valid  output  1  y holds a valid result.
- out_ready  input  1  downstream accepts y this cycle.
- y  output  width  result.
- busy  output  1  any valid beat held inside the pipeline.

Behaviour:
- Op encoding:
  - 000 a^b
  - 001 ~(a^b)
  - 010 a&b
  - 011 a|b
  - 100 ~(a&b)
  - 101 ~(a|b)
  - 110 a&~b
  - 111 reserved: result all-zero
- Width rules:
  - Operands are zero-extended to 48 bits. a drives A:B concatenation (a[17:0] to B, a[47:18] to A); b drives C.
  - y = P[width-1:0]. Inverted ops produce all-ones in unused upper bits internally; only [width-1:0] is visible.
- Op-to-DSP mapping: op maps to ALUMODE/OPMODE per UG579 logic-unit table (X=A:B, Y=0, Z=C, OPMODE[3:2] selects the 0 or all-ones Y term).
- Register mapping:
  - PREG=1 always.
  - latency>=2: AREG=BREG=CREG=1, ALUMODEREG=OPMODEREG=1.
  - latency=3: AREG=BREG=2, plus one fabric stage on C and on the op/control path so every field stays aligned.
  - MREG=ADREG=DREG=0.
- Advance signal: advance = ~out_valid | out_ready.
  - in_ready = advance while reset is high; in_ready = 0 while reset is low.
  - Every DSP clock-enable and every fabric pipeline register uses advance as its enable. The whole pipeline stalls as one unit and no beat is dropped or duplicated.
- Valid tracking: valid shift register of length latency.
  - Stage 0 loads in_valid & in_ready when advance=1; later stages shift when advance=1. out_valid = last stage.
  - busy = OR of all stages.
  - Bubbles are preserved. Throughput is 1 beat/cycle when out_ready is held high.
- Latency: a beat accepted at cycle N appears with out_valid=1 at cycle N+latency if out_ready was high throughout. A stall of k cycles adds k.
- Hold under backpressure: while out_valid=1 and out_ready=0, y and out_valid stay stable until the handshake.
- Reset:
  - On a clock edge with reset=0, all valid stages clear, all DSP registers clear (RST* driven by ~reset), fabric registers clear, and y=0.
  - Outputs after reset: out_valid=0, busy=0, in_ready=1 from the first cycle reset=1.
  - Reset mid-operation discards all in-flight beats with no partial output.
- Simultaneous accept/emit: when out_valid & out_ready & in_valid in the same cycle, the new beat is accepted and the old one leaves.
- No X propagation: y is don't-care when out_valid=0 but must never be X after reset.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 and random a/b → out_valid=0, busy=0, y=0, in_ready=0; first cycle after reset=1 → in_ready=1, out_valid=0.
- All ops, width=48, latency=2, a=48'hF0F0_1234_5678, b=48'h0FF0_FFFF_0000, out_ready=1, op 000..111 on consecutive cycles → 8 results in order starting cycle N+2, e.g. xor=FF00_EDCB_5678, and=00F0_1234_0000, 111→0.
- Narrow width: width=7, latency=1, a=7'h55, b=7'h7F, op=101 (nor) → y=7'h00 at N+1; op=001 (xnor) → y=7'h55.
- Backpressure, latency=3, out_ready toggles 1,0,0,1,… with 20 streaming beats (a=i, b=0, op=000) → y sequence 0..19 exactly once each; y stable while out_ready=0; in_ready=0 exactly on stall cycles.
- Bubbles, latency=2: in_valid pattern 1,0,1,1,0,1 → out_valid pattern identical, shifted by 2 cycles.
- Reset mid-flight, latency=3: accept 3 beats, assert reset=0 for 1 cycle → no out_valid ever for those beats; next accepted beat emerges exactly 3 cycles later.
